// File: rtl/trap_pkg.sv
// rtl/trap_pkg.sv - shared width, cause codes and state encoding for the trap sequencer
package trap_pkg;

   localparam int XLEN = 32;

   localparam int unsigned EXC_INSTR_MISALIGNED = 0;
   localparam int unsigned EXC_ILLEGAL          = 2;
   localparam int unsigned EXC_BREAKPOINT       = 3;
   localparam int unsigned EXC_LD_MISALIGNED    = 4;
   localparam int unsigned EXC_ST_MISALIGNED    = 6;
   localparam int unsigned EXC_ECALL_M          = 11;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      TRAP     = 2'd1,
      REDIRECT = 2'd2,
      RET      = 2'd3
   } trap_state_t;

endpackage

// File: rtl/trap_prio_enc.sv
// rtl/trap_prio_enc.sv - combinational exception priority encoder (cause and tval selection)
module trap_prio_enc
   import trap_pkg::*;
#(
   parameter int XLEN = trap_pkg::XLEN
) (
   input  logic [XLEN-1:0] pc_i,
   input  logic [XLEN-1:0] tval_i,
   input  logic            instr_misaligned_i,
   input  logic            illegal_instr_i,
   input  logic            ebreak_i,
   input  logic            ecall_i,
   input  logic            ld_misaligned_i,
   input  logic            st_misaligned_i,
   output logic            exc_o,
   output logic [XLEN-1:0] cause_o,
   output logic [XLEN-1:0] tval_o
);

   // highest-priority flag wins; ebreak reports its own pc, ecall reports zero
   always_comb begin
      exc_o   = instr_misaligned_i | illegal_instr_i | ebreak_i |
                ecall_i | ld_misaligned_i | st_misaligned_i;
      cause_o = '0;
      tval_o  = '0;
      if (instr_misaligned_i) begin
         cause_o = XLEN'(EXC_INSTR_MISALIGNED);
         tval_o  = tval_i;
      end else if (illegal_instr_i) begin
         cause_o = XLEN'(EXC_ILLEGAL);
         tval_o  = tval_i;
      end else if (ebreak_i) begin
         cause_o = XLEN'(EXC_BREAKPOINT);
         tval_o  = pc_i;
      end else if (ecall_i) begin
         cause_o = XLEN'(EXC_ECALL_M);
         tval_o  = '0;
      end else if (ld_misaligned_i) begin
         cause_o = XLEN'(EXC_LD_MISALIGNED);
         tval_o  = tval_i;
      end else if (st_misaligned_i) begin
         cause_o = XLEN'(EXC_ST_MISALIGNED);
         tval_o  = tval_i;
      end
   end

endmodule

// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - machine-mode trap sequencer; optional TRAP_CNT_EN adds trap_cnt_o
module trap_ctrl
   import trap_pkg::*;
#(
   parameter int XLEN = trap_pkg::XLEN
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            instr_v_i,
   input  logic [XLEN-1:0] pc_i,
   input  logic [XLEN-1:0] tval_i,
   input  logic            instr_misaligned_i,
   input  logic            illegal_instr_i,
   input  logic            ebreak_i,
   input  logic            ecall_i,
   input  logic            ld_misaligned_i,
   input  logic            st_misaligned_i,
   input  logic            mret_i,
   input  logic [XLEN-1:0] mtvec_q_i,
   input  logic [XLEN-1:0] mepc_q_i,
`ifdef TRAP_CNT_EN
   output logic [XLEN-1:0] trap_cnt_o,
`endif
   output logic            ready_o,
   output logic            exception_q_o,
   output logic [XLEN-1:0] mcause_q_o,
   output logic [XLEN-1:0] mtval_q_o,
   output logic [XLEN-1:0] mepc_q_o,
   output logic            flush_v_o,
   output logic            redirect_v_o,
   output logic [XLEN-1:0] redirect_pc_o
);

   trap_state_t     state_q, state_d;
   logic [XLEN-1:0] mcause_q, mcause_d;
   logic [XLEN-1:0] mtval_q, mtval_d;
   logic [XLEN-1:0] mepc_q, mepc_d;

   logic            exc;
   logic [XLEN-1:0] enc_cause;
   logic [XLEN-1:0] enc_tval;

   trap_prio_enc #(.XLEN(XLEN)) u_prio_enc (
      .pc_i               (pc_i),
      .tval_i             (tval_i),
      .instr_misaligned_i (instr_misaligned_i),
      .illegal_instr_i    (illegal_instr_i),
      .ebreak_i           (ebreak_i),
      .ecall_i            (ecall_i),
      .ld_misaligned_i    (ld_misaligned_i),
      .st_misaligned_i    (st_misaligned_i),
      .exc_o              (exc),
      .cause_o            (enc_cause),
      .tval_o             (enc_tval)
   );

   // next state, CSR capture on accept, and state-decoded outputs
   always_comb begin
      state_d       = state_q;
      mcause_d      = mcause_q;
      mtval_d       = mtval_q;
      mepc_d        = mepc_q;
      ready_o       = 1'b0;
      exception_q_o = 1'b0;
      flush_v_o     = 1'b0;
      redirect_v_o  = 1'b0;
      redirect_pc_o = '0;
      unique case (state_q)
         IDLE: begin
            ready_o = 1'b1;
            if (instr_v_i) begin
               if (exc) begin
                  state_d  = TRAP;
                  mcause_d = enc_cause;
                  mtval_d  = enc_tval;
                  mepc_d   = pc_i & ~XLEN'(1);
               end else if (mret_i) begin
                  state_d = RET;
               end
            end
         end
         TRAP: begin
            exception_q_o = 1'b1;
            flush_v_o     = 1'b1;
            state_d       = REDIRECT;
         end
         REDIRECT: begin
            // mtvec sampled now so a just-committed mtvec write is seen; always base mode
            redirect_v_o  = 1'b1;
            redirect_pc_o = {mtvec_q_i[XLEN-1:2], 2'b00};
            flush_v_o     = 1'b1;
            state_d       = IDLE;
         end
         RET: begin
            redirect_v_o  = 1'b1;
            redirect_pc_o = mepc_q_i & ~XLEN'(3);
            flush_v_o     = 1'b1;
            state_d       = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // state and captured CSR values
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         mcause_q <= '0;
         mtval_q  <= '0;
         mepc_q   <= '0;
      end else begin
         state_q  <= state_d;
         mcause_q <= mcause_d;
         mtval_q  <= mtval_d;
         mepc_q   <= mepc_d;
      end
   end

   assign mcause_q_o = mcause_q;
   assign mtval_q_o  = mtval_q;
   assign mepc_q_o   = mepc_q;

`ifdef TRAP_CNT_EN
   logic [XLEN-1:0] trap_cnt_q, trap_cnt_d;

   // one count per strobe cycle, wrapping naturally at all-ones
   always_comb begin
      trap_cnt_d = trap_cnt_q;
      if (exception_q_o) begin
         trap_cnt_d = trap_cnt_q + XLEN'(1);
      end
   end

   // trap counter register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         trap_cnt_q <= '0;
      end else begin
         trap_cnt_q <= trap_cnt_d;
      end
   end

   assign trap_cnt_o = trap_cnt_q;
`endif

endmodule

// File: tb/tb_trap_ctrl.sv
// tb/tb_trap_ctrl.sv - scoreboard bench for trap_ctrl
module tb_trap_ctrl;

   logic        clk;
   logic        reset_n;
   logic        instr_v_i;
   logic [31:0] pc_i;
   logic [31:0] tval_i;
   logic        instr_misaligned_i;
   logic        illegal_instr_i;
   logic        ebreak_i;
   logic        ecall_i;
   logic        ld_misaligned_i;
   logic        st_misaligned_i;
   logic        mret_i;
   logic [31:0] mtvec_q_i;
   logic [31:0] mepc_q_i;
   logic        ready_o;
   logic        exception_q_o;
   logic [31:0] mcause_q_o;
   logic [31:0] mtval_q_o;
   logic [31:0] mepc_q_o;
   logic        flush_v_o;
   logic        redirect_v_o;
   logic [31:0] redirect_pc_o;
`ifdef TRAP_CNT_EN
   logic [31:0] trap_cnt_o;
`endif

   trap_ctrl #(.XLEN(32)) dut (
      .clk                (clk),
      .reset_n            (reset_n),
      .instr_v_i          (instr_v_i),
      .pc_i               (pc_i),
      .tval_i             (tval_i),
      .instr_misaligned_i (instr_misaligned_i),
      .illegal_instr_i    (illegal_instr_i),
      .ebreak_i           (ebreak_i),
      .ecall_i            (ecall_i),
      .ld_misaligned_i    (ld_misaligned_i),
      .st_misaligned_i    (st_misaligned_i),
      .mret_i             (mret_i),
      .mtvec_q_i          (mtvec_q_i),
      .mepc_q_i           (mepc_q_i),
`ifdef TRAP_CNT_EN
      .trap_cnt_o         (trap_cnt_o),
`endif
      .ready_o            (ready_o),
      .exception_q_o      (exception_q_o),
      .mcause_q_o         (mcause_q_o),
      .mtval_q_o          (mtval_q_o),
      .mepc_q_o           (mepc_q_o),
      .flush_v_o          (flush_v_o),
      .redirect_v_o       (redirect_v_o),
      .redirect_pc_o      (redirect_pc_o)
   );

   typedef struct {
      logic        redir;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] c;
      int          cyc;
   } ev_t;

   ev_t sb[$];
   int  checks = 0;
   int  errors = 0;
   int  cyc = 0;
   int  n_traps = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // independent reference of the cause/tval table; f = {imis, ill, ebrk, ecall, ldmis, stmis}
   function automatic logic [63:0] ref_enc(input logic [5:0] f, input logic [31:0] pc,
                                           input logic [31:0] tv);
      if (f[5]) return {32'd0, tv};
      if (f[4]) return {32'd2, tv};
      if (f[3]) return {32'd3, pc};
      if (f[2]) return {32'd11, 32'd0};
      if (f[1]) return {32'd4, tv};
      return {32'd6, tv};
   endfunction

   // present one instruction, hold it until accepted, queue what the DUT must produce
   task automatic drive(input logic [5:0] f, input logic mret, input logic [31:0] pc,
                        input logic [31:0] tv, input logic [31:0] mtvec, input logic [31:0] mepc);
      int   budget = 0;
      ev_t  e;
      logic [63:0] r;
      {instr_misaligned_i, illegal_instr_i, ebreak_i, ecall_i, ld_misaligned_i, st_misaligned_i} = f;
      mret_i    = mret;
      pc_i      = pc;
      tval_i    = tv;
      mtvec_q_i = mtvec;
      mepc_q_i  = mepc;
      instr_v_i = 1'b1;
      while (!ready_o && budget < 20) begin
         @(negedge clk);
         budget++;
      end
      check_eq("accept_wait", 32'(budget < 20), 32'd1);
      if (f != 6'd0) begin
         r = ref_enc(f, pc, tv);
         e = '{redir: 1'b0, a: r[63:32], b: r[31:0], c: pc & ~32'd1, cyc: cyc + 1};
         sb.push_back(e);
         e = '{redir: 1'b1, a: {mtvec[31:2], 2'b00}, b: 32'd0, c: 32'd0, cyc: cyc + 2};
         sb.push_back(e);
         n_traps++;
      end else if (mret) begin
         e = '{redir: 1'b1, a: mepc & ~32'd3, b: 32'd0, c: 32'd0, cyc: cyc + 1};
         sb.push_back(e);
      end
      @(negedge clk);
      instr_v_i = 1'b0;
      {instr_misaligned_i, illegal_instr_i, ebreak_i, ecall_i, ld_misaligned_i, st_misaligned_i} = '0;
      mret_i = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // scoreboard consumer: every strobe or redirect must match the next queued event
   always @(negedge clk) begin
      ev_t e;
      if (reset_n && (exception_q_o || redirect_v_o)) begin
         check_eq("sb_pending", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check_eq("ev_kind", 32'(redirect_v_o), 32'(e.redir));
            check_eq("ev_cycle", 32'(cyc), 32'(e.cyc));
            check_eq("ev_flush", 32'(flush_v_o), 32'd1);
            check_eq("ev_ready", 32'(ready_o), 32'd0);
            if (exception_q_o) begin
               check_eq("no_overlap", 32'(redirect_v_o), 32'd0);
               check_eq("mcause", mcause_q_o, e.a);
               check_eq("mtval", mtval_q_o, e.b);
               check_eq("mepc", mepc_q_o, e.c);
            end else begin
               check_eq("redirect_pc", redirect_pc_o, e.a);
            end
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_ready"}, 32'(ready_o), 32'd1);
      check_eq({tag, "_exc"}, 32'(exception_q_o), 32'd0);
      check_eq({tag, "_flush"}, 32'(flush_v_o), 32'd0);
      check_eq({tag, "_redir"}, 32'(redirect_v_o), 32'd0);
      check_eq({tag, "_rpc"}, redirect_pc_o, 32'd0);
      check_eq({tag, "_mcause"}, mcause_q_o, 32'd0);
      check_eq({tag, "_mtval"}, mtval_q_o, 32'd0);
      check_eq({tag, "_mepc"}, mepc_q_o, 32'd0);
   endtask

   localparam logic [31:0] MTVEC = 32'h8000_0003;

   initial begin
      int d;
      logic [5:0] f;
      reset_n   = 1'b0;
      instr_v_i = 1'b0;
      pc_i      = '0;
      tval_i    = '0;
      {instr_misaligned_i, illegal_instr_i, ebreak_i, ecall_i, ld_misaligned_i, st_misaligned_i} = '0;
      mret_i    = 1'b0;
      mtvec_q_i = MTVEC;
      mepc_q_i  = '0;
      #1;
      check_reset_outputs("reset");
      idle(3);
      reset_n = 1'b1;
      idle(2);

      // 1: illegal instruction, then ready must be back three cycles after the accept edge
      d = cyc;
      drive(6'b010000, 1'b0, 32'h100, 32'h0000_FFFF, MTVEC, 32'h0);
      idle(2);
      check_eq("ready_back", 32'(ready_o), 32'd1);
      check_eq("ready_latency", 32'(cyc), 32'(d + 3));

      // 2: ecall outranks load misaligned
      drive(6'b000110, 1'b0, 32'h200, 32'h1003, MTVEC, 32'h0);
      idle(3);

      // 3: plain mret, mret with misaligned mepc, mret masked by illegal
      drive(6'b000000, 1'b1, 32'h300, 32'h0, MTVEC, 32'h204);
      idle(2);
      drive(6'b000000, 1'b1, 32'h304, 32'h0, MTVEC, 32'h207);
      idle(2);
      drive(6'b010000, 1'b1, 32'h308, 32'hDEAD, MTVEC, 32'h204);
      idle(3);

      // each flag on its own, odd pc to exercise epc bit-0 clearing
      for (int i = 0; i < 6; i++) begin
         f = 6'b1 << i;
         drive(f, 1'b0, 32'h1001 + 32'(i * 16), $urandom, 32'h0000_1000 + 32'(i), 32'h0);
         idle(3);
      end

      // valid without ready-accept conditions: instr_v low with flags set does nothing
      {illegal_instr_i, mret_i} = 2'b11;
      idle(4);
      {illegal_instr_i, mret_i} = 2'b00;

      // 4: second instruction held through TRAP/REDIRECT is taken exactly once
      d = cyc;
      drive(6'b001000, 1'b0, 32'h400, 32'h0, MTVEC, 32'h0);
      drive(6'b000001, 1'b0, 32'h404, 32'hBEEF, MTVEC, 32'h0);
      idle(4);
      check_eq("sb_drained", 32'(sb.size()), 32'd0);

`ifdef TRAP_CNT_EN
      check_eq("trap_cnt", trap_cnt_o, 32'(n_traps));
`endif

      // 5: reset during REDIRECT clears everything at once and leaves no redirect behind
      drive(6'b010000, 1'b0, 32'h500, 32'h1, MTVEC, 32'h0);
      @(posedge clk);
      #1;
      check_eq("pre_rst_redir", 32'(redirect_v_o), 32'd1);
      sb.delete();
      reset_n = 1'b0;
      #1;
      check_reset_outputs("async_rst");
`ifdef TRAP_CNT_EN
      check_eq("trap_cnt_rst", trap_cnt_o, 32'd0);
`endif
      @(negedge clk);
      reset_n = 1'b1;
      idle(5);
      check_eq("post_rst_ready", 32'(ready_o), 32'd1);
      check_eq("sb_final", 32'(sb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Machine-mode trap sequencer between the commit stage and the CSR file.
- Takes per-instruction exception flags and MRET from commit and picks the highest-priority cause.
- Registers the mcause/mtval/mepc update as a one-cycle pulse to the CSR file, then flushes the pipeline and redirects fetch to mtvec, or to mepc for MRET.
- Stalls commit while a trap sequence is in flight.

Parameters:
XLEN, 32, datapath width; all cause/tval/pc values are XLEN bits.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
instr_v_i  in  1  committing instruction valid
pc_i  in  XLEN  PC of committing instruction
tval_i  in  XLEN  faulting address (misaligned cases) or instruction word (illegal)
instr_misaligned_i  in  1  instruction address misaligned
illegal_instr_i  in  1  illegal instruction
ebreak_i  in  1  EBREAK
ecall_i  in  1  ECALL
ld_misaligned_i  in  1  load address misaligned
st_misaligned_i  in  1  store/AMO address misaligned
mret_i  in  1  MRET committing
mtvec_q_i  in  XLEN  current mtvec from CSR file
mepc_q_i  in  XLEN  current mepc from CSR file
ready_o  out  1  commit may present a new instruction
exception_q_o  out  1  one-cycle CSR trap-update strobe
mcause_q_o  out  XLEN  cause to write
mtval_q_o  out  XLEN  tval to write
mepc_q_o  out  XLEN  epc to write
flush_v_o  out  1  kill all younger in-flight instructions
redirect_v_o  out  1  fetch redirect valid
redirect_pc_o  out  XLEN  fetch redirect target

Behaviour:
- Reset: state IDLE; every output 0 except ready_o=1. An asynchronous reset taken in any state returns to IDLE on assertion. No CSR strobe is produced after reset is deasserted.
- Accept: an instruction is accepted when instr_v_i & ready_o. Inputs are ignored when ready_o=0.
- Exception detect: exc = OR of the six exception flags.
- Priority encoder (mcause value / mtval value):
  - instr_misaligned: 0 / tval_i
  - illegal: 2 / tval_i
  - ebreak: 3 / pc_i
  - ecall: 11 / 0
  - ld_misaligned: 4 / tval_i
  - st_misaligned: 6 / tval_i
- States: IDLE, TRAP, REDIRECT, RET.
- IDLE, accepted with exc=1 -> TRAP:
  - mcause_q_o, mtval_q_o and mepc_q_o (= pc_i & ~1) are registered at this edge.
  - mret_i is ignored when exc=1.
- IDLE, accepted with exc=0 and mret=1 -> RET.
- IDLE, otherwise: stay in IDLE.
- TRAP (1 cycle): exception_q_o=1, flush_v_o=1, ready_o=0 -> REDIRECT.
- REDIRECT (1 cycle):
  - redirect_v_o=1, redirect_pc_o = {mtvec_q_i[XLEN-1:2], 2'b00}, flush_v_o=1, ready_o=0 -> IDLE.
  - mtvec_q_i is sampled here, so an mtvec write committed just before the trap is honoured. Vector mode is ignored because exceptions always go to base.
- RET (1 cycle): redirect_v_o=1, redirect_pc_o = mepc_q_i & ~3, flush_v_o=1, ready_o=0 -> IDLE.
- Latency:
  - Exception accepted at edge N: strobe in cycle N+1, redirect in N+2, ready_o=1 again in N+3.
  - MRET accepted at edge N: redirect in N+1.
- Output hold: mcause/mtval/mepc_q_o hold their last values outside TRAP. They are meaningful only while exception_q_o=1.
- Back-to-back: a second trap cannot start until the sequence in flight completes. A redirect never overlaps a strobe.

Optional Feature:
- Macro: TRAP_CNT_EN.
- Defined:
  - Adds output trap_cnt_o [XLEN-1:0], reset 0.
  - Increments by 1 on every cycle where exception_q_o=1 and wraps from all-ones to 0.
  - MRET does not count.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package (trap_pkg):
  - XLEN.
  - Cause constants EXC_INSTR_MISALIGNED=0, EXC_ILLEGAL=2, EXC_BREAKPOINT=3, EXC_LD_MISALIGNED=4, EXC_ST_MISALIGNED=6, EXC_ECALL_M=11.
  - Enum trap_state_t {IDLE, TRAP, REDIRECT, RET}.
- Sub-module trap_prio_enc: purely combinational priority encoder from the six flags plus pc_i/tval_i to {exc, cause, tval}.

Test Plan:
1. Illegal instruction, pc_i=0x100, tval_i=0x0000FFFF, mtvec_q_i=0x80000003:
   - N+1: exception_q_o=1, mcause=2, mtval=0xFFFF, mepc=0x100, flush_v_o=1.
   - N+2: redirect_v_o=1 to 0x80000000.
   - N+3: ready_o=1.
2. ECALL and ld_misaligned together, pc=0x200, tval=0x1003 -> mcause=11, mtval=0, mepc=0x200.
3. MRET with mepc_q_i=0x204 -> next cycle redirect_v_o=1, pc=0x204, flush_v_o=1, no exception_q_o. MRET plus illegal -> trap path with mcause=2, no RET.
4. Second valid instruction held during TRAP/REDIRECT -> ignored until ready_o=1, then accepted exactly once.
5. reset_n pulsed low during REDIRECT -> all outputs 0 immediately, ready_o=1, no redirect after release.
6. With TRAP_CNT_EN defined: 3 traps and 2 MRETs -> trap_cnt_o=3. Preload near all-ones -> wraps to 0.
